// File: rtl/udcounter_pkg.sv
// udcounter_pkg: shared defaults and the count type for the SBqM occupancy
// counter (ud_counter and its falling-edge detectors).
package udcounter_pkg;

  localparam int UDC_WIDTH    = 3;
  localparam int UDC_CAPACITY = 7;

  typedef logic [UDC_WIDTH-1:0] udc_count_t;

endpackage

// File: rtl/udc_fall_detect.sv
// udc_fall_detect: turns an active-low sensor line into a one-cycle event
// pulse on each 1->0 transition. With UDCOUNTER_SYNC_EN defined, the line
// first passes through a 2-flop synchronizer (reset to 1), adding 2 cycles
// of latency; otherwise the line is assumed synchronous to Clk.
module udc_fall_detect
  import udcounter_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  input  logic i_line,
  output logic o_fall
);

  logic w_sample;
  logic r_prev;

`ifdef UDCOUNTER_SYNC_EN
  logic r_sync_p0;
  logic r_sync_p1;

  // Two-flop synchronizer; idles high so reset looks like "line released".
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sync_p0 <= 1'b1;
      r_sync_p1 <= 1'b1;
    end else begin
      r_sync_p0 <= i_line;
      r_sync_p1 <= r_sync_p0;
    end
  end

  assign w_sample = r_sync_p1;
`else
  assign w_sample = i_line;
`endif

  // Previous sample; reset to 1 so a line already low at release counts once.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= w_sample;
    end
  end

  // Event only on high-to-low; holding low or releasing produces nothing.
  assign o_fall = r_prev & ~w_sample;

endmodule

// File: rtl/ud_counter.sv
// ud_counter: saturating up/down occupancy counter for the single-bank queue
// manager. Active-low Up/Down sensor lines are edge-detected into one-cycle
// events; the count saturates at 0 and CAPACITY, and simultaneous entry and
// exit cancel. Optional input synchronizers are enabled by the macro
// UDCOUNTER_SYNC_EN (+2 cycles of event latency); default build has none.
module ud_counter
  import udcounter_pkg::*;
#(
  parameter int WIDTH    = UDC_WIDTH,
  parameter int CAPACITY = UDC_CAPACITY
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Up,
  input  logic             Down,
  output logic [WIDTH-1:0] Count,
  output logic             FullFlag,
  output logic             EmptyFlag
);

  localparam logic [WIDTH-1:0] CAP = WIDTH'(CAPACITY);

  logic             w_inc;
  logic             w_dec;
  logic [WIDTH-1:0] r_count;

  // Next occupancy with saturation at both ends; opposing events cancel.
  function automatic logic [WIDTH-1:0] sat_step(
    input logic [WIDTH-1:0] cnt,
    input logic             inc,
    input logic             dec
  );
    logic [WIDTH-1:0] nxt;
    nxt = cnt;
    if (inc && !dec && (cnt < CAP)) begin
      nxt = cnt + 1'b1;
    end else if (dec && !inc && (cnt != '0)) begin
      nxt = cnt - 1'b1;
    end
    return nxt;
  endfunction

  udc_fall_detect u_up_detect (
    .Clk    (Clk),
    .Reset  (Reset),
    .i_line (Up),
    .o_fall (w_inc)
  );

  udc_fall_detect u_down_detect (
    .Clk    (Clk),
    .Reset  (Reset),
    .i_line (Down),
    .o_fall (w_dec)
  );

  // Occupancy register; reset wins over any event in the same cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_count <= '0;
    end else begin
      r_count <= sat_step(r_count, w_inc, w_dec);
    end
  end

  assign Count     = r_count;
  assign FullFlag  = (r_count == CAP);
  assign EmptyFlag = (r_count == '0);

endmodule

// File: tb/tb_ud_counter.sv
// tb_ud_counter: directed test of ud_counter (fill, drain, simultaneous
// events, long holds, reset mid-run). Works in both builds; with
// UDCOUNTER_SYNC_EN defined the expected event latency is 2 extra cycles.
module tb_ud_counter;

`ifdef UDCOUNTER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       Clk;
  logic       Reset;
  logic       Up;
  logic       Down;
  logic [2:0] Count;
  logic       FullFlag;
  logic       EmptyFlag;

  int n_checks;
  int n_errors;
  int exp_cnt;

  ud_counter #(.WIDTH(3), .CAPACITY(7)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Up        (Up),
    .Down      (Down),
    .Count     (Count),
    .FullFlag  (FullFlag),
    .EmptyFlag (EmptyFlag)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic settle();
    for (int k = 0; k < LAT; k++) tick();
  endtask

  task automatic pulse_up();
    Up = 1'b0;
    tick();
    Up = 1'b1;
    tick();
    settle();
  endtask

  task automatic pulse_down();
    Down = 1'b0;
    tick();
    Down = 1'b1;
    tick();
    settle();
  endtask

  task automatic pulse_both();
    Up   = 1'b0;
    Down = 1'b0;
    tick();
    Up   = 1'b1;
    Down = 1'b1;
    tick();
    settle();
  endtask

  task automatic check_state(input string tag, input int exp);
    check({tag, "_count"}, int'(Count), exp);
    check({tag, "_full"},  int'(FullFlag), (exp == 7) ? 1 : 0);
    check({tag, "_empty"}, int'(EmptyFlag), (exp == 0) ? 1 : 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    Reset = 1'b1;
    Up    = 1'b1;
    Down  = 1'b1;

    // Reset for two cycles with idle sensors
    tick();
    tick();
    Reset = 1'b0;
    check_state("reset", 0);
    tick();
    check_state("reset_idle", 0);

    // First entry: check event latency, then settle
    Up = 1'b0;
    tick();
    check("lat_first_edge", int'(Count), (LAT == 0) ? 1 : 0);
    Up = 1'b1;
    tick();
    check("lat_mid", int'(Count), (LAT == 0) ? 1 : 0);
    tick();
    check("lat_after", int'(Count), 1);
    settle();

    // Fill: 8 more pulses, saturating at 7
    for (int i = 2; i <= 9; i++) begin
      pulse_up();
      exp_cnt = (i > 7) ? 7 : i;
      check_state($sformatf("fill%0d", i), exp_cnt);
    end

    // Drain: 9 pulses, stopping at 0 with no wrap
    for (int i = 1; i <= 9; i++) begin
      pulse_down();
      exp_cnt = (7 - i < 0) ? 0 : 7 - i;
      check_state($sformatf("drain%0d", i), exp_cnt);
    end

    // Simultaneous at 0, 3 and 7
    pulse_both();
    check_state("both_at0", 0);
    for (int i = 0; i < 3; i++) pulse_up();
    check_state("up_to3", 3);
    pulse_both();
    check_state("both_at3", 3);
    for (int i = 0; i < 4; i++) pulse_up();
    check_state("up_to7", 7);
    pulse_both();
    check_state("both_at7", 7);

    // Long hold: one event per falling edge only
    for (int i = 0; i < 5; i++) pulse_down();
    check_state("down_to2", 2);
    Up = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check_state("hold_up_low", 3);
    Up = 1'b1;
    tick();
    settle();
    check_state("hold_up_rel", 3);
    Down = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check_state("hold_dn_low", 2);
    Down = 1'b1;
    tick();
    settle();
    check_state("hold_dn_rel", 2);

    // Reset mid-run coinciding with an Up falling edge, line held low
    for (int i = 0; i < 3; i++) pulse_up();
    check_state("up_to5", 5);
    Reset = 1'b1;
    Up    = 1'b0;
    tick();
    check_state("rst_mid", 0);
    Reset = 1'b0;
    tick();
    check("rst_rel_edge", int'(Count), (LAT == 0) ? 1 : 0);
    settle();
    check_state("rst_rel_event", 1);
    for (int i = 0; i < 5; i++) tick();
    check_state("rst_rel_hold", 1);
    Up = 1'b1;
    tick();
    settle();
    check_state("rst_rel_release", 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
